// File: rtl/exp_iter_pkg.sv
// Shared constants, state encoding and reciprocal table generator for the e^x unit.
// DECIMAL_BITS must stay equal to the fraction width used by the ln(x) block.
package exp_iter_pkg;

    // Fixed-point fraction width shared with the log-domain blocks.
    localparam int unsigned DECIMAL_BITS = 10;

    // 1.0 in the fixed-point format.
    localparam logic signed [31:0] ONE = 32'sd1024;

    // Clamp value for inputs above the accepted range.
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    // round(2^DECIMAL_BITS / k), evaluated at elaboration time only.
    function automatic logic [31:0] recip_val(input int unsigned k);
        int unsigned num;
        if (k == 0) begin
            return '0;
        end
        num = (32'd2 << DECIMAL_BITS) + k;
        return num / (2 * k);
    endfunction

endpackage

// File: rtl/exp_recip_rom.sv
// Reciprocal table 1/k in fixed point, combinational read indexed by the term counter.
module exp_recip_rom
    import exp_iter_pkg::*;
#(
    parameter int unsigned N_TERMS = 8,
    parameter int unsigned AW      = $clog2(N_TERMS)
) (
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   rdata_o
);

    // Table is padded to a power of two so every counter value indexes a real entry.
    logic [31:0] rom [2**AW];

    for (genvar g = 0; g < 2**AW; g++) begin : g_rom
        assign rom[g] = recip_val(g);
    end

    // Asynchronous read: the term update uses the entry in the same cycle.
    always_comb begin
        rdata_o = rom[addr_i];
    end

endmodule

// File: rtl/exp_iter.sv
// Iterative e^x by Taylor series: one shared multiply-accumulate step per term,
// ready/valid on both sides, out-of-range operands clamp immediately.
module exp_iter
    import exp_iter_pkg::*;
#(
    parameter int unsigned N_TERMS = 8,
    parameter int signed   X_MAX   = 2048,
    parameter int signed   X_MIN   = -2048
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] output_data,
    output logic        sat
);

    localparam int unsigned KW = $clog2(N_TERMS);
    localparam logic [KW-1:0] K_LAST = KW'(N_TERMS - 1);

    state_e state_q, state_d;

    logic signed [31:0] x_q, x_d;
    logic signed [31:0] term_q, term_d;
    logic signed [31:0] sum_q, sum_d;
    logic [KW-1:0]      k_q, k_d;
    logic [31:0]        out_q, out_d;
    logic               sat_q, sat_d;

    logic [31:0]        recip;
    logic               accept;
    logic               over_hi;
    logic               under_lo;

    logic signed [63:0] prod_a;
    logic signed [63:0] p_full;
    logic signed [63:0] prod_b;
    logic signed [63:0] t_full;
    logic signed [31:0] t;
    logic signed [31:0] sum_nx;

    exp_recip_rom #(
        .N_TERMS (N_TERMS),
        .AW      (KW)
    ) u_recip_rom (
        .addr_i  (k_q),
        .rdata_o (recip)
    );

    assign accept   = in_valid && in_ready;
    assign over_hi  = $signed(data) > X_MAX;
    assign under_lo = $signed(data) < X_MIN;

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: clamp goes straight to DONE, in-range runs N_TERMS-1 CALC cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (over_hi || under_lo) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (k_q == K_LAST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs are pure decodes of the registered state.
    always_comb begin
        in_ready  = (state_q == StIdle) && !RST;
        out_valid = (state_q == StDone);
    end

    // One series step: t = ((term * x) >>> F) * (1/k) >>> F, both shifts flooring.
    always_comb begin
        prod_a = $signed({{32{term_q[31]}}, term_q}) * $signed({{32{x_q[31]}}, x_q});
        p_full = prod_a >>> DECIMAL_BITS;
        prod_b = p_full * $signed({32'b0, recip});
        t_full = prod_b >>> DECIMAL_BITS;
        t      = t_full[31:0];
        sum_nx = sum_q + t;
    end

    // Datapath next-state: load on accept, accumulate in CALC, publish on the last term.
    always_comb begin
        x_d    = x_q;
        term_d = term_q;
        sum_d  = sum_q;
        k_d    = k_q;
        out_d  = out_q;
        sat_d  = sat_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (over_hi) begin
                        out_d = SAT_MAX;
                        sat_d = 1'b1;
                    end else if (under_lo) begin
                        out_d = '0;
                        sat_d = 1'b1;
                    end else begin
                        x_d    = $signed(data);
                        term_d = ONE;
                        sum_d  = ONE;
                        k_d    = KW'(1);
                    end
                end
            end
            StCalc: begin
                term_d = t;
                sum_d  = sum_nx;
                k_d    = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    // Truncation can push a tiny result below zero; e^x never is.
                    out_d = sum_nx[31] ? '0 : sum_nx;
                    sat_d = 1'b0;
                end
            end
            StDone: begin
                // Result held stable while the consumer applies backpressure.
            end
            default: begin
            end
        endcase
    end

    // Datapath registers with synchronous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            x_q    <= '0;
            term_q <= '0;
            sum_q  <= '0;
            k_q    <= '0;
            out_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            term_q <= term_d;
            sum_q  <= sum_d;
            k_q    <= k_d;
            out_q  <= out_d;
            sat_q  <= sat_d;
        end
    end

    assign output_data = out_q;
    assign sat         = sat_q;

endmodule
